// File: rtl/dfi_wrdata_en_gen.sv
// rtl/dfi_wrdata_en_gen.sv - per-phase DFI write-data-enable generator with programmable write latency
module dfi_wrdata_en_gen #(
    parameter int MAX_WL   = 31,
    parameter int WL_WIDTH = 5
) (
    input  logic                sclk,
    input  logic                srst_n,
    input  logic                wr_cmd_p0,
    input  logic                wr_cmd_p1,
    input  logic                wr_cmd_p2,
    input  logic                wr_cmd_p3,
    input  logic [WL_WIDTH-1:0] cfg_wr_latency,
    output logic                dfi_wrdata_en_p0,
    output logic                dfi_wrdata_en_p1,
    output logic                dfi_wrdata_en_p2,
    output logic                dfi_wrdata_en_p3,
    output logic                busy,
    output logic                err_overlap,
    output logic                err_cfg
);

    // Bit k of the pending vector is the enable for phase 4*(cycle+1)+k, i.e. the
    // phases after the ones currently shown by the output register.
    localparam int                  SR_LEN   = MAX_WL + 8;
    localparam logic [WL_WIDTH:0]   MAX_WL_W = (WL_WIDTH + 1)'(MAX_WL);
    localparam logic [SR_LEN-1:0]   BURST    = {{(SR_LEN - 4){1'b0}}, 4'b1111};

    logic [3:0]          cmd;
    logic [SR_LEN-1:0]   pend_q, pend_d;
    logic [3:0]          en_q, en_d;
    logic [WL_WIDTH-1:0] lact_q, lact_d;
    logic [WL_WIDTH-1:0] cfg_seen_q, cfg_seen_d;
    logic                err_ov_q, err_ov_d;
    logic                err_cfg_q, err_cfg_d;
    logic [SR_LEN-1:0]   sched;
    logic [SR_LEN-1:0]   win;
    logic                busy_int;

    assign cmd = {wr_cmd_p3, wr_cmd_p2, wr_cmd_p1, wr_cmd_p0};

    // Seed new bursts into the pending window, detect overlaps, advance 4 phases and handle latency updates.
    always_comb begin
        sched      = pend_q;
        win        = '0;
        err_ov_d   = 1'b0;
        busy_int   = (|pend_q) | (|en_q) | (|cmd);
        lact_d     = lact_q;
        cfg_seen_d = cfg_seen_q;
        err_cfg_d  = 1'b0;

        // Commands are folded in phase order so two commands in one cycle also count as overlapping.
        for (int p = 0; p < 4; p++) begin
            win = BURST << (p + int'(lact_q));
            if (cmd[p[1:0]]) begin
                if (|(sched & win)) begin
                    err_ov_d = 1'b1;
                end
                sched = sched | win;
            end
        end

        en_d   = sched[3:0];
        pend_d = sched >> 4;

        // Latency only changes while nothing is in flight; an over-range request is clamped and flagged once.
        if (!busy_int) begin
            cfg_seen_d = cfg_wr_latency;
            if ({1'b0, cfg_wr_latency} > MAX_WL_W) begin
                lact_d    = WL_WIDTH'(MAX_WL);
                err_cfg_d = (cfg_wr_latency != cfg_seen_q);
            end else begin
                lact_d = cfg_wr_latency;
            end
        end
    end

    // State and output registers; reset drops every in-flight burst.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            pend_q     <= '0;
            en_q       <= '0;
            lact_q     <= '0;
            cfg_seen_q <= '0;
            err_ov_q   <= 1'b0;
            err_cfg_q  <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            en_q       <= en_d;
            lact_q     <= lact_d;
            cfg_seen_q <= cfg_seen_d;
            err_ov_q   <= err_ov_d;
            err_cfg_q  <= err_cfg_d;
        end
    end

    assign dfi_wrdata_en_p0 = en_q[0];
    assign dfi_wrdata_en_p1 = en_q[1];
    assign dfi_wrdata_en_p2 = en_q[2];
    assign dfi_wrdata_en_p3 = en_q[3];
    assign err_overlap      = err_ov_q;
    assign err_cfg          = err_cfg_q;
    // Commands seen during reset must not show up as busy.
    assign busy             = srst_n & busy_int;

endmodule

// File: tb/tb_dfi_wrdata_en_gen.sv
// tb/tb_dfi_wrdata_en_gen.sv - directed self-checking bench for dfi_wrdata_en_gen
module tb_dfi_wrdata_en_gen;

    localparam int MAX_WL   = 20;
    localparam int WL_WIDTH = 5;

    logic                sclk = 1'b0;
    logic                srst_n;
    logic                wr_cmd_p0, wr_cmd_p1, wr_cmd_p2, wr_cmd_p3;
    logic [WL_WIDTH-1:0] cfg_wr_latency;
    logic                dfi_wrdata_en_p0, dfi_wrdata_en_p1, dfi_wrdata_en_p2, dfi_wrdata_en_p3;
    logic                busy, err_overlap, err_cfg;

    int checks = 0;
    int errors = 0;

    dfi_wrdata_en_gen #(.MAX_WL(MAX_WL), .WL_WIDTH(WL_WIDTH)) dut (
        .sclk             (sclk),
        .srst_n           (srst_n),
        .wr_cmd_p0        (wr_cmd_p0),
        .wr_cmd_p1        (wr_cmd_p1),
        .wr_cmd_p2        (wr_cmd_p2),
        .wr_cmd_p3        (wr_cmd_p3),
        .cfg_wr_latency   (cfg_wr_latency),
        .dfi_wrdata_en_p0 (dfi_wrdata_en_p0),
        .dfi_wrdata_en_p1 (dfi_wrdata_en_p1),
        .dfi_wrdata_en_p2 (dfi_wrdata_en_p2),
        .dfi_wrdata_en_p3 (dfi_wrdata_en_p3),
        .busy             (busy),
        .err_overlap      (err_overlap),
        .err_cfg          (err_cfg)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] en_nib();
        return {dfi_wrdata_en_p3, dfi_wrdata_en_p2, dfi_wrdata_en_p1, dfi_wrdata_en_p0};
    endfunction

    task automatic drive_cmd(input logic [3:0] c);
        {wr_cmd_p3, wr_cmd_p2, wr_cmd_p1, wr_cmd_p0} = c;
    endtask

    // Program a latency, wait for idle so it is latched, then idle two more cycles.
    task automatic settle(input logic [WL_WIDTH-1:0] cfg_v);
        int n;
        n = 0;
        @(posedge sclk); #1;
        drive_cmd(4'h0);
        cfg_wr_latency = cfg_v;
        while (busy === 1'b1 && n < 200) begin
            @(posedge sclk); #1;
            n++;
        end
        check("settle_idle", 32'(busy), 32'h0);
        repeat (2) @(posedge sclk);
    endtask

    // Eight relative cycles; nibble k of cmds/exp_en and bit k of exp_busy/exp_ov belong to cycle k.
    task automatic run(input string tag, input logic [WL_WIDTH-1:0] cfg0, input logic [31:0] cmds,
                       input logic [31:0] exp_en, input logic [7:0] exp_busy, input logic [7:0] exp_ov);
        for (int k = 0; k < 8; k++) begin
            @(posedge sclk); #1;
            drive_cmd(cmds[4*k +: 4]);
            if (k == 0) cfg_wr_latency = cfg0;
            @(negedge sclk);
            check($sformatf("%s_en_c%0d", tag, k), 32'(en_nib()), 32'(exp_en[4*k +: 4]));
            check($sformatf("%s_busy_c%0d", tag, k), 32'(busy), 32'(exp_busy[k]));
            check($sformatf("%s_ovl_c%0d", tag, k), 32'(err_overlap), 32'(exp_ov[k]));
        end
    endtask

    initial begin
        srst_n         = 1'b0;
        cfg_wr_latency = '0;
        drive_cmd(4'h0);

        // Held in reset while commands toggle.
        for (int i = 0; i < 4; i++) begin
            @(posedge sclk); #1;
            drive_cmd((i % 2 == 0) ? 4'hF : 4'hA);
            @(negedge sclk);
            check($sformatf("rst_en_%0d", i), 32'(en_nib()), 32'h0);
            check($sformatf("rst_busy_%0d", i), 32'(busy), 32'h0);
            check($sformatf("rst_err_%0d", i), 32'({err_overlap, err_cfg}), 32'h0);
        end
        @(posedge sclk); #1;
        srst_n = 1'b1;
        drive_cmd(4'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge sclk);
            check($sformatf("post_rst_en_%0d", i), 32'(en_nib()), 32'h0);
            check($sformatf("post_rst_busy_%0d", i), 32'(busy), 32'h0);
            @(posedge sclk);
        end

        // L=0, p0: phases 4..7 -> cycle 1.
        settle(5'd0);
        run("l0_p0", 5'd0, 32'h0000_0001, 32'h0000_00F0, 8'h03, 8'h00);
        // L=5, p2: t=2 -> phases 11..14.
        settle(5'd5);
        run("l5_p2", 5'd5, 32'h0000_0004, 32'h0000_7800, 8'h0F, 8'h00);
        // L=3, p1 twice, 4 phases apart -> gapless 8..15.
        settle(5'd3);
        run("l3_b2b", 5'd3, 32'h0000_0022, 32'h0000_FF00, 8'h0F, 8'h00);
        // L=0, p0+p2 same cycle -> 4..9, overlap flagged.
        settle(5'd0);
        run("l0_same", 5'd0, 32'h0000_0005, 32'h0000_03F0, 8'h07, 8'h02);
        // L=0, p3 then p1 next cycle (spacing 2) -> 7..12, overlap flagged.
        run("l0_xovl", 5'd0, 32'h0000_0028, 32'h0000_1F80, 8'h0F, 8'h04);
        // L=0, p0 then p1 next cycle (spacing 5) -> 4..7, 9..12 with one-phase gap.
        run("l0_gap", 5'd0, 32'h0000_0021, 32'h0000_1EF0, 8'h0F, 8'h00);

        // L=2 active, cfg moves to 7 while busy: both bursts keep L=2.
        settle(5'd2);
        run("cfg_hold", 5'd7, 32'h0000_0101, 32'h0003_C3C0, 8'h1F, 8'h00);
        // Idle again, so L=7 now applies: phases 11..14.
        settle(5'd7);
        run("cfg_new", 5'd7, 32'h0000_0001, 32'h0000_7800, 8'h0F, 8'h00);

        // Over-range latency clamps to MAX_WL with a single err_cfg pulse.
        settle(5'd0);
        @(posedge sclk); #1;
        cfg_wr_latency = 5'd31;
        @(negedge sclk);
        check("err_cfg_before", 32'(err_cfg), 32'h0);
        @(posedge sclk);
        @(negedge sclk);
        check("err_cfg_pulse", 32'(err_cfg), 32'h1);
        @(posedge sclk);
        @(negedge sclk);
        check("err_cfg_after", 32'(err_cfg), 32'h0);
        // Clamped L=20: phases 24..27 -> cycle 6.
        run("wl_clamp", 5'd31, 32'h0000_0001, 32'h0F00_0000, 8'h7F, 8'h00);

        // Reset mid-burst at L=8: bursts for cycles 3..5, reset during cycle 3.
        settle(5'd8);
        for (int k = 0; k < 4; k++) begin
            @(posedge sclk); #1;
            drive_cmd((k < 3) ? 4'h1 : 4'h0);
            @(negedge sclk);
            check($sformatf("mid_rst_pre_en_c%0d", k), 32'(en_nib()), (k == 3) ? 32'hF : 32'h0);
        end
        #1;
        srst_n = 1'b0;
        drive_cmd(4'hF);
        #1;
        check("mid_rst_en_drop", 32'(en_nib()), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        @(posedge sclk); #1;
        srst_n = 1'b1;
        drive_cmd(4'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge sclk);
            check($sformatf("mid_rst_post_en_%0d", k), 32'(en_nib()), 32'h0);
            check($sformatf("mid_rst_post_busy_%0d", k), 32'(busy), 32'h0);
            @(posedge sclk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
